// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Purpose
//   MEM/WB pipeline register and writeback logic for the RV32I pipeline.
//   - Captures MEM-stage results on each posedge.
//   - Aligns and sign/zero-extends load data from the registered fields.
//   - Selects the writeback source and drives the register_file write port.
//   Misaligned loads are flagged on misalign_o, and their register write is
//   suppressed.
//
// Configuration
//   WB_INSTRET_EN  When defined, instret_o counts retired instructions.
//                  Retired means valid in WB, not stalled and not misaligned.
//                  When undefined, instret_o is tied to zero.
//
// Parameters
//   INSTRET_W           Width of the retired-instruction counter.
//
// Ports
//   clk                 Clock. All state updates on posedge.
//   reset               Asynchronous, active-high reset.
//   mem_valid_i         MEM stage holds a real instruction.
//   alu_result_i        ALU result, or the load/store byte address.
//   pc_plus4_i          PC+4, used as the JAL/JALR link value.
//   load_data_i         Raw aligned word read from data memory.
//   funct3_i            Load width/sign (LB, LH, LW, LBU, LHU).
//   result_src_i        Writeback source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
//   reg_write_i         The instruction writes rd.
//   rd_i                Destination register.
//   stall_i             Hold the MEM/WB register contents.
//   flush_i             Kill the instruction entering WB. Wins over stall_i.
//   wr_data_o           Write data to the register file.
//   reg_file_writeen_o  Write enable to the register file.
//   dest_reg_o          Write address to the register file.
//   wb_valid_o          The WB stage holds a valid instruction.
//   misalign_o          The valid load in WB is misaligned.
//   instret_o           Retired-instruction count.
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid_i,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          pc_plus4_i,
  input  logic [31:0]          load_data_i,
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           result_src_i,
  input  logic                 reg_write_i,
  input  logic [4:0]           rd_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic [31:0]          wr_data_o,
  output logic                 reg_file_writeen_o,
  output logic [4:0]           dest_reg_o,
  output logic                 wb_valid_o,
  output logic                 misalign_o,
  output logic [INSTRET_W-1:0] instret_o
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_RSVD = 2'b11
  } result_src_e;

  // MEM/WB pipeline register fields.
  logic        valid_q;
  logic [31:0] alu_q;
  logic [31:0] pc4_q;
  logic [31:0] ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  src_q;
  logic        rw_q;
  logic [4:0]  rd_q;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its pre-edge inputs. This block holds a handful of registers, not
  // a memory array, so resetting all of them is cheap. Resetting them also
  // makes the bubble outputs deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      pc4_q   <= '0;
      ld_q    <= '0;
      f3_q    <= '0;
      src_q   <= '0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
    end else if (flush_i) begin
      // Insert a bubble. The payload fields are left untouched.
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= mem_valid_i;
      alu_q   <= alu_result_i;
      pc4_q   <= pc_plus4_i;
      ld_q    <= load_data_i;
      f3_q    <= funct3_i;
      src_q   <= result_src_i;
      rw_q    <= reg_write_i;
      rd_q    <= rd_i;
    end
  end

  // Load alignment and extension. Loads with funct3[1:0]==00 are byte loads.
  // Loads with funct3[1:0]==01 are half loads. Everything else is treated as
  // a word load. A funct3[2] value of 1 selects zero extension.
  logic [1:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;
  logic [31:0] load_ext;
  logic        misaligned;

  assign off  = alu_q[1:0];
  assign sext = ~f3_q[2];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    byte_v     = ld_q[7:0];
    half_v     = off[1] ? ld_q[31:16] : ld_q[15:0];
    load_ext   = ld_q;
    misaligned = 1'b0;
    case (off)
      2'd1:    byte_v = ld_q[15:8];
      2'd2:    byte_v = ld_q[23:16];
      2'd3:    byte_v = ld_q[31:24];
      default: byte_v = ld_q[7:0];
    endcase
    case (f3_q[1:0])
      2'b00: load_ext = {{24{sext & byte_v[7]}}, byte_v};
      2'b01: begin
        load_ext   = {{16{sext & half_v[15]}}, half_v};
        misaligned = off[0];
      end
      default: begin
        load_ext   = ld_q;
        misaligned = (off != 2'd0);
      end
    endcase
  end

  // Writeback source select. The reserved encoding behaves like ALU.
  always_comb begin
    wr_data_o = alu_q;
    case (result_src_e'(src_q))
      SRC_LOAD: wr_data_o = load_ext;
      SRC_PC4:  wr_data_o = pc4_q;
      default:  wr_data_o = alu_q;
    endcase
  end

  assign wb_valid_o         = valid_q;
  assign misalign_o         = valid_q & (src_q == SRC_LOAD) & misaligned;
  assign dest_reg_o         = rd_q;
  // A held (stalled) valid instruction keeps writing the same value. That
  // repeated write is harmless.
  assign reg_file_writeen_o = valid_q & rw_q & (rd_q != 5'd0) & ~misalign_o;

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (wb_valid_o && !stall_i && !misalign_o) begin
      instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule
